ram_conv_pingpong: RTL and testbench

Double-buffered feature-map RAM for the convolution datapath. A producer streams one frame of FRAME_LEN pixels into one bank while the convolution engine random-reads the previous complete frame from the other bank. Banks swap under a fill/release handshake. The block is the parametrised successor of the single-bank conv RAM and sits between the layer-output writer and the next layer's window address generator.

---
 rtl/ram_conv_pingpong.sv | 108 ++++++++++
 tb/tb_ram_conv_pingpong.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_conv_pingpong.sv
// Double-buffered feature-map RAM: a producer fills one bank sequentially while
// the convolution engine random-reads the previous complete frame from the other.
module ram_conv_pingpong #(
  parameter int DATA_W    = 10,
  parameter int ADDR_W    = 12,
  parameter int FRAME_LEN = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wrValid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_wrReady,
  input  logic              i_rdEn,
  input  logic [ADDR_W-1:0] i_addrOut,
  output logic [DATA_W-1:0] o_data,
  output logic              o_rdValid,
  output logic              o_frameReady,
  input  logic              i_frameDone,
  output logic              o_wrBank,
  output logic              o_rdBank
);

  localparam int                DEPTH     = 2 * (2 ** ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0]   FRAME_END = (ADDR_W + 1)'(FRAME_LEN);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_mem_q;

  logic [1:0]        r_full;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic              r_rd_valid;
  logic              r_rd_zero;

  logic              w_wr_accept;
  logic              w_wr_last;
  logic              w_release;
  logic              w_rd_accept;
  logic              w_addr_oob;
  logic [ADDR_W:0]   w_wr_addr;
  logic [ADDR_W:0]   w_rd_addr;
  logic [1:0]        w_full_next;

  assign w_wr_accept = i_wrValid && !r_full[r_wr_bank];
  assign w_wr_last   = w_wr_accept && (r_wr_cnt == LAST_ADDR);
  assign w_release   = i_frameDone && r_full[r_rd_bank];
  assign w_rd_accept = i_rdEn && r_full[r_rd_bank];
  assign w_addr_oob  = {1'b0, i_addrOut} >= FRAME_END;
  assign w_wr_addr   = {r_wr_bank, r_wr_cnt};
  assign w_rd_addr   = {r_rd_bank, i_addrOut};

  // A release and a fill in the same cycle always target different banks:
  // release needs full[rdBank]=1, an accepted write needs full[wrBank]=0.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_full_next = r_full;
    if (w_release) w_full_next[r_rd_bank] = 1'b0;
    if (w_wr_last) w_full_next[r_wr_bank] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full    <= 2'b00;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= '0;
    end else begin
      r_full <= w_full_next;
      if (w_wr_accept) begin
        if (w_wr_last) begin
          r_wr_bank <= ~r_wr_bank;
          r_wr_cnt  <= '0;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end
      if (w_release) r_rd_bank <= ~r_rd_bank;
    end
  end

  // NOTE: the RAM array has no reset so it maps onto a block RAM; contents after reset are don't-care.
  always_ff @(posedge i_clk) begin
    if (w_wr_accept) r_mem[w_wr_addr] <= i_data;
    if (w_rd_accept) r_mem_q <= r_mem[w_rd_addr];
  end

  // r_rd_zero masks the RAM output for out-of-frame reads and after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_zero  <= 1'b1;
    end else begin
      r_rd_valid <= w_rd_accept;
      if (w_rd_accept) r_rd_zero <= w_addr_oob;
    end
  end

  assign o_data       = r_rd_zero ? '0 : r_mem_q;
  assign o_rdValid    = r_rd_valid;
  assign o_wrReady    = !r_full[r_wr_bank];
  assign o_frameReady = r_full[r_rd_bank];
  assign o_wrBank     = r_wr_bank;
  assign o_rdBank     = r_rd_bank;

endmodule

// File: tb/tb_ram_conv_pingpong.sv
// Self-checking bench for ram_conv_pingpong: a 16-word instance for handshake corners
// and a default-size instance for the full 4096-word frame.
module tb_ram_conv_pingpong;

  localparam int S_DW = 10;
  localparam int S_AW = 5;
  localparam int S_FL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Small instance
  logic            s_rst = 1'b1, s_wr_valid = 1'b0, s_rd_en = 1'b0, s_frame_done = 1'b0;
  logic [S_DW-1:0] s_data = '0;
  logic [S_AW-1:0] s_addr = '0;
  logic [S_DW-1:0] s_rd_data;
  logic            s_wr_ready, s_rd_valid, s_frame_ready, s_wr_bank, s_rd_bank;

  ram_conv_pingpong #(.DATA_W(S_DW), .ADDR_W(S_AW), .FRAME_LEN(S_FL)) u_dut_small (
    .i_clk(clk), .i_rst(s_rst), .i_wrValid(s_wr_valid), .i_data(s_data),
    .o_wrReady(s_wr_ready), .i_rdEn(s_rd_en), .i_addrOut(s_addr), .o_data(s_rd_data),
    .o_rdValid(s_rd_valid), .o_frameReady(s_frame_ready), .i_frameDone(s_frame_done),
    .o_wrBank(s_wr_bank), .o_rdBank(s_rd_bank)
  );

  // Full-size instance (12-bit data so value = address fits)
  logic        b_rst = 1'b1, b_wr_valid = 1'b0, b_rd_en = 1'b0, b_frame_done = 1'b0;
  logic [11:0] b_data = '0, b_addr = '0;
  logic [11:0] b_rd_data;
  logic        b_wr_ready, b_rd_valid, b_frame_ready, b_wr_bank, b_rd_bank;

  ram_conv_pingpong #(.DATA_W(12), .ADDR_W(12), .FRAME_LEN(4096)) u_dut_big (
    .i_clk(clk), .i_rst(b_rst), .i_wrValid(b_wr_valid), .i_data(b_data),
    .o_wrReady(b_wr_ready), .i_rdEn(b_rd_en), .i_addrOut(b_addr), .o_data(b_rd_data),
    .o_rdValid(b_rd_valid), .o_frameReady(b_frame_ready), .i_frameDone(b_frame_done),
    .o_wrBank(b_wr_bank), .o_rdBank(b_rd_bank)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard of expected small-instance read responses
  typedef struct {
    logic [S_DW-1:0] data;
    int              due;
  } sb_t;
  sb_t sb_q[$];

  task automatic expect_read(input logic [S_DW-1:0] d);
    sb_t e;
    e.data = d;
    e.due  = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic issue_read(input logic [S_AW-1:0] a, input logic [S_DW-1:0] d);
    s_rd_en = 1'b1;
    s_addr  = a;
    expect_read(d);
    tick();
    s_rd_en = 1'b0;
  endtask

  task automatic write_frame_s(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      s_wr_valid = 1'b1;
      s_data     = S_DW'(base + i);
      tick();
    end
    s_wr_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      sb_t e;
      e = sb_q.pop_front();
      check("rd_valid", 32'(s_rd_valid), 32'd1);
      check("rd_data", 32'(s_rd_data), 32'(e.data));
    end else begin
      check("rd_idle", 32'(s_rd_valid), 32'd0);
    end
  end

  typedef struct {
    logic            rd_en;
    logic [S_AW-1:0] addr;
    logic            frame_done;
    logic            exp_rd;
    logic [S_DW-1:0] exp_data;
    logic            exp_fr;
    logic            exp_rb;
    logic            exp_wrr;
  } vec_t;
  vec_t vecs[10];

  initial begin
    // Both banks full: bank0 = 100+a, bank1 = 200+a, rdBank 0, wrBank 0.
    vecs[0] = '{1'b1, 5'd3,  1'b0, 1'b1, 10'd103, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 5'd0,  1'b0, 1'b1, 10'd100, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 5'd20, 1'b0, 1'b1, 10'd0,   1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 5'd7,  1'b1, 1'b1, 10'd107, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 5'd7,  1'b0, 1'b1, 10'd207, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 5'd31, 1'b0, 1'b1, 10'd0,   1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 5'd0,  1'b1, 1'b1, 10'd200, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 5'd5,  1'b0, 1'b0, 10'd0,   1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 5'd0,  1'b1, 1'b0, 10'd0,   1'b0, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 5'd0,  1'b0, 1'b0, 10'd0,   1'b0, 1'b0, 1'b1};

    tick();
    tick();
    check("rst_wr_ready", 32'(s_wr_ready), 32'd1);
    check("rst_frame_ready", 32'(s_frame_ready), 32'd0);
    check("rst_wr_bank", 32'(s_wr_bank), 32'd0);
    check("rst_rd_bank", 32'(s_rd_bank), 32'd0);
    check("rst_rd_data", 32'(s_rd_data), 32'd0);
    s_rst = 1'b0;
    tick();

    // Fill bank 0; frame ready only after the last word
    write_frame_s(100, 15);
    check("fill0_not_ready", 32'(s_frame_ready), 32'd0);
    write_frame_s(115, 1);
    check("fill0_ready", 32'(s_frame_ready), 32'd1);
    check("fill0_wr_bank", 32'(s_wr_bank), 32'd1);
    check("fill0_wr_ready", 32'(s_wr_ready), 32'd1);
    issue_read(5'd15, 10'd115);

    // Fill bank 1; both full stalls the producer
    write_frame_s(200, 16);
    check("both_full_wr_ready", 32'(s_wr_ready), 32'd0);
    check("both_full_wr_bank", 32'(s_wr_bank), 32'd0);
    s_wr_valid = 1'b1;
    s_data     = 10'h3FF;
    tick();
    tick();
    check("stall_wr_ready", 32'(s_wr_ready), 32'd0);
    check("stall_wr_bank", 32'(s_wr_bank), 32'd0);
    s_wr_valid = 1'b0;

    for (int i = 0; i < 10; i++) begin
      s_rd_en      = vecs[i].rd_en;
      s_addr       = vecs[i].addr;
      s_frame_done = vecs[i].frame_done;
      if (vecs[i].exp_rd) expect_read(vecs[i].exp_data);
      tick();
      check($sformatf("vec%0d_frame_ready", i), 32'(s_frame_ready), 32'(vecs[i].exp_fr));
      check($sformatf("vec%0d_rd_bank", i), 32'(s_rd_bank), 32'(vecs[i].exp_rb));
      check($sformatf("vec%0d_wr_ready", i), 32'(s_wr_ready), 32'(vecs[i].exp_wrr));
      check($sformatf("vec%0d_wr_bank", i), 32'(s_wr_bank), 32'd0);
    end
    s_rd_en      = 1'b0;
    s_frame_done = 1'b0;

    // Fill completes on bank 1 in the same cycle bank 0 is released
    write_frame_s(300, 16);
    check("fill2_ready", 32'(s_frame_ready), 32'd1);
    check("fill2_wr_bank", 32'(s_wr_bank), 32'd1);
    write_frame_s(400, 15);
    s_wr_valid   = 1'b1;
    s_data       = 10'd415;
    s_frame_done = 1'b1;
    tick();
    s_wr_valid   = 1'b0;
    s_frame_done = 1'b0;
    check("simul_rd_bank", 32'(s_rd_bank), 32'd1);
    check("simul_wr_bank", 32'(s_wr_bank), 32'd0);
    check("simul_frame_ready", 32'(s_frame_ready), 32'd1);
    check("simul_wr_ready", 32'(s_wr_ready), 32'd1);
    issue_read(5'd15, 10'd415);
    issue_read(5'd2, 10'd402);
    tick();
    tick();

    // Reset mid-frame discards everything; new frame restarts at bank 0 address 0
    write_frame_s(500, 7);
    s_rst = 1'b1;
    tick();
    check("mid_rst_wr_ready", 32'(s_wr_ready), 32'd1);
    check("mid_rst_frame_ready", 32'(s_frame_ready), 32'd0);
    check("mid_rst_wr_bank", 32'(s_wr_bank), 32'd0);
    check("mid_rst_rd_bank", 32'(s_rd_bank), 32'd0);
    s_rst = 1'b0;
    tick();
    s_rd_en = 1'b1;
    s_addr  = 5'd1;
    tick();
    s_rd_en = 1'b0;
    write_frame_s(600, 15);
    check("restart_not_ready", 32'(s_frame_ready), 32'd0);
    check("restart_wr_bank", 32'(s_wr_bank), 32'd0);
    write_frame_s(615, 1);
    check("restart_ready", 32'(s_frame_ready), 32'd1);
    check("restart_rd_bank", 32'(s_rd_bank), 32'd0);
    check("restart_wr_bank1", 32'(s_wr_bank), 32'd1);
    check("restart_wr_ready", 32'(s_wr_ready), 32'd1);
    issue_read(5'd0, 10'd600);
    issue_read(5'd6, 10'd606);
    issue_read(5'd15, 10'd615);
    tick();
    tick();

    // Full-size frame: value = address, then reads 0, 1, 4095 back to back
    b_rst = 1'b0;
    tick();
    check("big_rst_wr_ready", 32'(b_wr_ready), 32'd1);
    check("big_rst_frame_ready", 32'(b_frame_ready), 32'd0);
    for (int a = 0; a < 4096; a++) begin
      b_wr_valid = 1'b1;
      b_data     = 12'(a);
      tick();
      if (a == 4094) check("big_not_ready", 32'(b_frame_ready), 32'd0);
    end
    b_wr_valid = 1'b0;
    check("big_ready", 32'(b_frame_ready), 32'd1);
    check("big_wr_bank", 32'(b_wr_bank), 32'd1);
    b_rd_en = 1'b1;
    b_addr  = 12'd0;
    tick();
    check("big_rd0_valid", 32'(b_rd_valid), 32'd1);
    check("big_rd0_data", 32'(b_rd_data), 32'd0);
    b_addr = 12'd1;
    tick();
    check("big_rd1_valid", 32'(b_rd_valid), 32'd1);
    check("big_rd1_data", 32'(b_rd_data), 32'd1);
    b_addr = 12'd4095;
    tick();
    check("big_rd4095_valid", 32'(b_rd_valid), 32'd1);
    check("big_rd4095_data", 32'(b_rd_data), 32'd4095);
    b_rd_en = 1'b0;
    tick();
    check("big_rd_done", 32'(b_rd_valid), 32'd0);

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
